cyclic_cache_req_splitter: RTL
==============================

Name: cyclic_cache_req_splitter

Overview:
- Upstream request front-end for the cyclic cache user port.
- Accepts one multi-word, word-addressed burst request (read or write), splits it into USER_DW-aligned chunks and issues them on user_re/user_we/user_len/user_adr/user_wdat.
- Write: packs a DW word stream into chunks. Read: buffers chunk returns in a FIFO and unpacks them into a backpressured DW word stream.

Parameters:
- DW, 32, data word width (bits).
- AW, 32, byte address width.
- USER_DW, 128, cache user data width.
- USER_MAX_LEN, USER_DW/DW, words per chunk.
- REQ_LEN_W, 8, width of req_len; burst = req_len+1 words (1..256).
- RFIFO_DEPTH, 4, read-return FIFO entries (each USER_DW + length); power of 2, ≥2.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- req_valid  in  1  burst request valid
- req_ready  out  1  burst accepted when valid&&ready
- req_we  in  1  1=write, 0=read
- req_adr  in  AW  start byte address, DW/8-aligned
- req_len  in  REQ_LEN_W  words-1
- wd_valid / wd_ready  in / out  1  write word stream handshake
- wd_data  in  DW  write word
- rd_valid / rd_ready  out / in  1  read word stream handshake
- rd_data  out  DW  read word
- rd_last  out  1  last word of burst
- busy  out  1  burst in progress or reads outstanding
- ready  in  1  cache accepts user_re/user_we this cycle
- user_re, user_we  out  1  chunk command, one-cycle
- user_len  out  $clog2(USER_MAX_LEN)  chunk words-1
- user_adr  out  AW  chunk start byte address
- user_wdat  out  USER_DW  write data, first word in bits [DW-1:0]
- user_rdat  in  USER_DW  read data, first word in bits [DW-1:0]
- user_rdat_vld  in  1  read chunk return; no backpressure

Behaviour:
- Reset: req_ready=0 for the first cycle after reset release, then 1. All other outputs are 0. FIFO is empty and counters are cleared.
- Reset mid-burst aborts everything: discards FIFO data, issues no further commands. Returns still in flight inside the cache are not tracked; integrator flushes the cache.
- States: IDLE, RD_ISSUE, WR_GATHER, WR_ISSUE, RD_DRAIN.
- IDLE: req_ready=1. On accept, latch adr and remaining=req_len+1, then go to RD_ISSUE or WR_GATHER. req_ready=0 in all other states.
- Chunk size: min(remaining, USER_MAX_LEN - word offset of adr within USER_DW). Chunks never cross a USER_DW boundary.
- user_len = chunk-1. After each chunk, adr += chunk*DW/8 and remaining -= chunk.
- Issue rule: user_re/user_we are driven only in a cycle with ready=1. Acceptance is the same cycle. Never both at once.
- RD_ISSUE: issue when ready && credit>0, where credit = RFIFO_DEPTH − occupied − outstanding.
  - outstanding +1 on issue, −1 on user_rdat_vld; simultaneous issue and return leave it unchanged.
  - After the last chunk, go to RD_DRAIN.
- user_rdat_vld pushes {data, len} into the FIFO. The FIFO never overflows, because credit guarantees space.
- Unpack: rd_data presents the current FIFO head word by index. Index advances on rd_valid&&rd_ready and pops the entry after word len.
- rd_last=1 on the final word of the burst, tracked by a separate delivered-word counter.
- RD_DRAIN → IDLE when rd_last is handshaken.
- WR_GATHER: wd_ready=1. Words are packed LSB-first into the pack register. When the count reaches chunk size, go to WR_ISSUE with wd_ready=0.
- WR_ISSUE: hold user_wdat stable and assert user_we when ready. After acceptance, go to WR_GATHER if remaining>0, else IDLE.
- Unused upper user_wdat bits are 0.
- busy = (state≠IDLE) || outstanding≠0 || FIFO not empty.
- Misaligned req_adr (low $clog2(DW/8) bits ≠ 0): low bits are ignored (truncated).

Optional Feature:
- Macro: CACHE_SPLIT_PERF_EN.
- With the macro, extra outputs are added:
  - perf_chunks (32b): +1 per issued chunk.
  - perf_stall (32b): +1 per cycle a chunk is pending but ready=0 or credit=0.
  - perf_clr (in, 1b): synchronous clear; wins over a same-cycle increment.
  - Counters saturate at all-ones.
- Without the macro, these ports and logic are absent.

Test Plan:
- Read, adr=0x0, len=7, ready=1, returns 2 cycles later → two chunks: user_adr 0x0 then 0x10, user_len=3 each; rd_data emits 8 words in order, rd_last on word 8.
- Write, adr=0x8, len=4 → chunks (0x8, len 1), (0x10, len 2); user_wdat[63:0] = words 0,1 for the first, [95:0] = words 2..4 for the second; upper bits 0.
- Read len=15, rd_ready=0 throughout, RFIFO_DEPTH=4 → exactly 4 user_re issued, then no more; raising rd_ready resumes, all 16 words correct.
- ready toggling 0/1 every cycle during a write burst → user_we only in ready=1 cycles, no chunk lost or duplicated.
- Single word, adr=0xC, len=0 → one chunk, user_len=0, adr 0xC; req_ready returns to 1 after completion.
- rstn asserted mid read burst → all outputs 0 immediately; a new burst after release completes correctly.

Source files
------------

// File: rtl/cyclic_cache_req_splitter_if.sv
// Bundle of the burst request, word streams and cache user-port signals of the
// cyclic cache request splitter. "slave" is the splitter, "master" its environment.
interface cyclic_cache_req_splitter_if #(
    parameter int DW        = 32,
    parameter int AW        = 32,
    parameter int USER_DW   = 128,
    parameter int REQ_LEN_W = 8
);
    localparam int ULW = $clog2(USER_DW / DW);

    // Every valid/ready pair transfers exactly when both are 1 at a rising clk edge;
    // a source holds valid and its payload stable until that edge.
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [AW-1:0]        req_adr;
    logic [REQ_LEN_W-1:0] req_len;
    logic                 wd_valid;
    logic                 wd_ready;
    logic [DW-1:0]        wd_data;
    logic                 rd_valid;
    logic                 rd_ready;
    logic [DW-1:0]        rd_data;
    logic                 rd_last;
    logic                 busy;
    logic                 ready;
    logic                 user_re;
    logic                 user_we;
    logic [ULW-1:0]       user_len;
    logic [AW-1:0]        user_adr;
    logic [USER_DW-1:0]   user_wdat;
    logic [USER_DW-1:0]   user_rdat;
    logic                 user_rdat_vld;
    logic [2:0]           dbg_state;

    modport master (
        output req_valid, req_we, req_adr, req_len, wd_valid, wd_data, rd_ready,
               ready, user_rdat, user_rdat_vld,
        input  req_ready, wd_ready, rd_valid, rd_data, rd_last, busy, user_re,
               user_we, user_len, user_adr, user_wdat, dbg_state
    );

    modport slave (
        input  req_valid, req_we, req_adr, req_len, wd_valid, wd_data, rd_ready,
               ready, user_rdat, user_rdat_vld,
        output req_ready, wd_ready, rd_valid, rd_data, rd_last, busy, user_re,
               user_we, user_len, user_adr, user_wdat, dbg_state
    );
endinterface

// File: rtl/cyclic_cache_req_splitter.sv
// Splits word-addressed bursts into USER_DW-aligned cache user-port chunks.
// Define CACHE_SPLIT_PERF_EN to add the perf_chunks/perf_stall counters.
module cyclic_cache_req_splitter #(
    parameter int DW           = 32,
    parameter int AW           = 32,
    parameter int USER_DW      = 128,
    parameter int USER_MAX_LEN = USER_DW / DW,
    parameter int REQ_LEN_W    = 8,
    parameter int RFIFO_DEPTH  = 4
) (
    input  logic clk,
    input  logic rstn,
`ifdef CACHE_SPLIT_PERF_EN
    input  logic        perf_clr,
    output logic [31:0] perf_chunks,
    output logic [31:0] perf_stall,
`endif
    cyclic_cache_req_splitter_if.slave bus
);
    localparam int BB   = $clog2(DW / 8);
    localparam int LB   = $clog2(USER_DW / 8);
    localparam int ULW  = $clog2(USER_MAX_LEN);
    localparam int CW   = $clog2(USER_MAX_LEN + 1);
    localparam int RW   = REQ_LEN_W + 1;
    localparam int FW   = $clog2(RFIFO_DEPTH);
    localparam int CNTW = $clog2(RFIFO_DEPTH + 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] RD_ISSUE  = 3'd1;
    localparam logic [2:0] WR_GATHER = 3'd2;
    localparam logic [2:0] WR_ISSUE  = 3'd3;
    localparam logic [2:0] RD_DRAIN  = 3'd4;

    logic [2:0]         state;
    logic               armed;
    logic [AW-1:0]      adr;
    logic [RW-1:0]      remaining;
    logic [RW-1:0]      total;
    logic [RW-1:0]      delivered;
    logic [USER_DW-1:0] pack;
    logic [CW-1:0]      gathered;
    logic [CNTW-1:0]    outstanding;
    logic [CNTW-1:0]    occupied;
    logic [CNTW-1:0]    credit;
    logic [FW-1:0]      wr_ptr;
    logic [FW-1:0]      rd_ptr;
    logic [FW-1:0]      iss_ptr;
    logic [ULW-1:0]     word_idx;
    logic [CW-1:0]      space;
    logic [CW-1:0]      chunk;
    logic [AW-1:0]      adr_next;
    logic               last_chunk;
    logic               issue_re;
    logic               issue_we;
    logic               req_fire;
    logic               rd_fire;
    logic               head_done;

    logic [USER_DW-1:0] fifo_data [RFIFO_DEPTH];
    logic [ULW-1:0]     fifo_len  [RFIFO_DEPTH];

    // A chunk ends at the remaining word count or at the next USER_DW line boundary.
    assign space      = CW'(USER_MAX_LEN) - CW'(adr[LB-1:BB]);
    assign chunk      = (remaining < RW'(space)) ? CW'(remaining) : space;
    assign adr_next   = adr + (AW'(chunk) << BB);
    assign last_chunk = (remaining == RW'(chunk));

    // Credit counts FIFO slots not yet claimed by buffered or in-flight returns.
    assign credit   = CNTW'(RFIFO_DEPTH) - occupied - outstanding;
    assign issue_re = (state == RD_ISSUE) && bus.ready && (credit != '0);
    assign issue_we = (state == WR_ISSUE) && bus.ready;

    assign req_fire  = bus.req_valid && bus.req_ready;
    assign rd_fire   = bus.rd_valid && bus.rd_ready;
    assign head_done = (word_idx == fifo_len[rd_ptr]);

    assign bus.req_ready = (state == IDLE) && armed;
    assign bus.wd_ready  = (state == WR_GATHER);
    assign bus.rd_valid  = (occupied != '0);
    assign bus.rd_data   = bus.rd_valid ? fifo_data[rd_ptr][int'(word_idx)*DW +: DW] : '0;
    assign bus.rd_last   = bus.rd_valid && (delivered == total - RW'(1));
    assign bus.busy      = (state != IDLE) || (outstanding != '0) || (occupied != '0);
    assign bus.user_re   = issue_re;
    assign bus.user_we   = issue_we;
    assign bus.user_len  = (issue_re || issue_we) ? ULW'(chunk - CW'(1)) : '0;
    assign bus.user_adr  = (issue_re || issue_we) ? adr : '0;
    assign bus.user_wdat = pack;
    assign bus.dbg_state = state;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            armed       <= 1'b0;
            adr         <= '0;
            remaining   <= '0;
            total       <= '0;
            delivered   <= '0;
            pack        <= '0;
            gathered    <= '0;
            outstanding <= '0;
            occupied    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            iss_ptr     <= '0;
            word_idx    <= '0;
        end else begin
            armed <= 1'b1;

            if (rd_fire) begin
                delivered <= delivered + RW'(1);
                if (head_done) begin
                    rd_ptr   <= rd_ptr + FW'(1);
                    word_idx <= '0;
                end else begin
                    word_idx <= word_idx + ULW'(1);
                end
            end

            case (state)
                IDLE: begin
                    if (req_fire) begin
                        adr       <= bus.req_adr & ~AW'((1 << BB) - 1);
                        remaining <= RW'(bus.req_len) + RW'(1);
                        total     <= RW'(bus.req_len) + RW'(1);
                        delivered <= '0;
                        gathered  <= '0;
                        pack      <= '0;
                        state     <= bus.req_we ? WR_GATHER : RD_ISSUE;
                    end
                end
                RD_ISSUE: begin
                    if (issue_re) begin
                        adr       <= adr_next;
                        remaining <= remaining - RW'(chunk);
                        if (last_chunk) state <= RD_DRAIN;
                    end
                end
                RD_DRAIN: begin
                    if (rd_fire && bus.rd_last) state <= IDLE;
                end
                WR_GATHER: begin
                    if (bus.wd_valid) begin
                        pack[int'(gathered)*DW +: DW] <= bus.wd_data;
                        gathered <= gathered + CW'(1);
                        if (gathered + CW'(1) == chunk) state <= WR_ISSUE;
                    end
                end
                WR_ISSUE: begin
                    if (issue_we) begin
                        adr       <= adr_next;
                        remaining <= remaining - RW'(chunk);
                        pack      <= '0;
                        gathered  <= '0;
                        state     <= last_chunk ? IDLE : WR_GATHER;
                    end
                end
                default: state <= IDLE;
            endcase

            if (issue_re) iss_ptr <= iss_ptr + FW'(1);
            if (bus.user_rdat_vld) wr_ptr <= wr_ptr + FW'(1);

            case ({issue_re, bus.user_rdat_vld})
                2'b10:   outstanding <= outstanding + CNTW'(1);
                2'b01:   outstanding <= outstanding - CNTW'(1);
                default: outstanding <= outstanding;
            endcase

            case ({bus.user_rdat_vld, rd_fire && head_done})
                2'b10:   occupied <= occupied + CNTW'(1);
                2'b01:   occupied <= occupied - CNTW'(1);
                default: occupied <= occupied;
            endcase
        end
    end

    // The length is parked in the slot reserved at issue; returns arrive in issue order.
    always_ff @(posedge clk) begin
        if (bus.user_rdat_vld) fifo_data[wr_ptr] <= bus.user_rdat;
        if (issue_re) fifo_len[iss_ptr] <= ULW'(chunk - CW'(1));
    end

`ifdef CACHE_SPLIT_PERF_EN
    logic chunk_pending;
    assign chunk_pending = (state == RD_ISSUE) || (state == WR_ISSUE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_chunks <= '0;
            perf_stall  <= '0;
        end else if (perf_clr) begin
            perf_chunks <= '0;
            perf_stall  <= '0;
        end else begin
            if ((issue_re || issue_we) && (perf_chunks != '1)) perf_chunks <= perf_chunks + 32'd1;
            if (chunk_pending && !(issue_re || issue_we) && (perf_stall != '1))
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif
endmodule
